io_bus_master: RTL and testbench

- CPU-side initiator of the memory-mapped IO bus; drives io_addr/io_dout/io_we/io_rd and samples io_din from the debug/IO unit.
- Executes direct single-beat accesses: LED, switches, raw valid flags.
- Runs the polled handshake in hardware: wait for the input-valid flag then read, or wait for the output-valid flag to clear then write.
- Stalls the CPU pipeline for the duration of each access; sits between the MEM stage and the IO bus.

---
 rtl/io_bus_master_pkg.sv | 36 +++
 rtl/io_bus_master_poll_cnt.sv | 30 +++
 rtl/io_bus_master.sv | 141 ++++++++++++++
 tb/tb_io_bus_master.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/io_bus_master_pkg.sv
// Shared constants and types for the IO bus initiator: bus address map,
// FSM encoding and the latched request record.
package io_bus_master_pkg;

  localparam logic [7:0] IO_LED         = 8'h00;
  localparam logic [7:0] IO_SW          = 8'h04;
  localparam logic [7:0] IO_POL_OUT_VLD = 8'h08;
  localparam logic [7:0] IO_POL_OUT     = 8'h0C;
  localparam logic [7:0] IO_POL_IN_VLD  = 8'h10;
  localparam logic [7:0] IO_POL_IN      = 8'h14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_POLL,
    ST_XFER,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } req_t;

  // Flag register polled before a handshake transfer.
  function automatic logic [7:0] poll_flag_addr(input logic we);
    return we ? IO_POL_OUT_VLD : IO_POL_IN_VLD;
  endfunction

  // Data register moved once the flag reports ready.
  function automatic logic [7:0] poll_data_addr(input logic we);
    return we ? IO_POL_OUT : IO_POL_IN;
  endfunction

endpackage

// File: rtl/io_bus_master_poll_cnt.sv
// Poll-attempt counter: clear, saturating increment and the timeout compare.
// LIMIT=0 means the timeout never fires.
module io_poll_cnt #(
  parameter int LIMIT = 0,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LAST = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign at_limit = (LIMIT != 0) && (cnt == LAST);

endmodule

// File: rtl/io_bus_master.sv
// CPU-side IO bus initiator: direct single-beat accesses and the hardware
// polled handshake, stalling the pipeline until the access completes.
//
// state  | meaning
// IDLE   | waiting for a MEM-stage IO request
// ACCESS | one direct read or write strobe at the latched address
// POLL   | reading the valid flag until it reports ready (or timeout)
// XFER   | one read of IN data or write of OUT data
// DONE   | response pulse; pipeline released
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int POLL_LIMIT = 0,
  parameter int CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_poll,
  input  logic [7:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  io_addr,
  output logic [31:0] io_dout,
  output logic        io_we,
  output logic        io_rd,
  input  logic [31:0] io_din
);

  state_t      state, state_nx;
  req_t        req_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic cnt_clr, cnt_inc, at_limit;
  logic capture, set_err, accept, ready;

  io_poll_cnt #(
    .LIMIT (POLL_LIMIT),
    .CNT_W (CNT_W)
  ) u_poll_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .clr      (cnt_clr),
    .inc      (cnt_inc),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    io_addr    = 8'h00;
    io_dout    = 32'h0;
    io_we      = 1'b0;
    io_rd      = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'h0;
    resp_err   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    capture    = 1'b0;
    set_err    = 1'b0;
    accept     = 1'b0;
    ready      = req_q.we ? ~io_din[0] : io_din[0];
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept   = 1'b1;
          cnt_clr  = 1'b1;
          state_nx = req_poll ? ST_POLL : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        io_addr  = req_q.addr;
        io_dout  = req_q.wdata;
        io_we    = req_q.we;
        io_rd    = ~req_q.we;
        capture  = ~req_q.we;
        state_nx = ST_DONE;
      end
      ST_POLL: begin
        io_rd   = 1'b1;
        io_addr = poll_flag_addr(req_q.we);
        if (ready) begin
          state_nx = ST_XFER;
        end else if (at_limit) begin
          set_err  = 1'b1;
          state_nx = ST_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_XFER: begin
        io_addr = poll_data_addr(req_q.we);
        if (req_q.we) begin
          io_we   = 1'b1;
          io_dout = req_q.wdata;
        end else begin
          io_rd   = 1'b1;
          capture = 1'b1;
        end
        state_nx = ST_DONE;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // rstn gates stall so every output is low while reset is asserted.
  assign stall = rstn && (state != ST_DONE) && (req_valid || (state != ST_IDLE));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        req_q   <= '{we: req_we, addr: req_addr, wdata: req_wdata};
        rdata_q <= 32'h0;
        err_q   <= 1'b0;
      end
      if (capture) rdata_q <= io_din;
      if (set_err) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master: direct read/write, polled read/write,
// poll timeout on a limited instance, and reset during a poll.
module tb_io_bus_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_valid_l, req_we, req_poll;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata, io_din;

  logic        stall_a, rv_a, err_a, we_a, rd_a;
  logic [31:0] rdata_a, dout_a;
  logic [7:0]  addr_a;
  logic        stall_l, rv_l, err_l, we_l, rd_l;
  logic [31:0] rdata_l, dout_l;
  logic [7:0]  addr_l;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  io_bus_master #(.POLL_LIMIT(0), .CNT_W(16)) u_dut (
    .clk (clk), .rstn (rstn),
    .req_valid (req_valid), .req_we (req_we), .req_poll (req_poll),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .stall (stall_a), .resp_valid (rv_a), .resp_rdata (rdata_a), .resp_err (err_a),
    .io_addr (addr_a), .io_dout (dout_a), .io_we (we_a), .io_rd (rd_a),
    .io_din (io_din)
  );

  io_bus_master #(.POLL_LIMIT(4), .CNT_W(16)) u_lim (
    .clk (clk), .rstn (rstn),
    .req_valid (req_valid_l), .req_we (req_we), .req_poll (req_poll),
    .req_addr (req_addr), .req_wdata (req_wdata),
    .stall (stall_l), .resp_valid (rv_l), .resp_rdata (rdata_l), .resp_err (err_l),
    .io_addr (addr_l), .io_dout (dout_l), .io_we (we_l), .io_rd (rd_l),
    .io_din (io_din)
  );

  // Packed view: {stall, resp_valid, resp_err, io_we, io_rd, io_addr, io_dout, resp_rdata}
  task automatic cmp(input string tag, input logic [76:0] obs, input logic [76:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic st, input logic rv, input logic er,
                       input logic we, input logic rd, input logic [7:0] ad,
                       input logic [31:0] dout, input logic [31:0] rdata);
    cmp(tag, {stall_a, rv_a, err_a, we_a, rd_a, addr_a, dout_a, rdata_a},
        {st, rv, er, we, rd, ad, dout, rdata});
  endtask

  task automatic chk_l(input string tag, input logic st, input logic rv, input logic er,
                       input logic we, input logic rd, input logic [7:0] ad,
                       input logic [31:0] dout, input logic [31:0] rdata);
    cmp(tag, {stall_l, rv_l, err_l, we_l, rd_l, addr_l, dout_l, rdata_l},
        {st, rv, er, we, rd, ad, dout, rdata});
  endtask

  // Advance to the next falling edge; outputs are then sampled #1 later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b1; req_valid_l = 1'b1;
    req_we = 1'b0; req_poll = 1'b0; req_addr = 8'h04; req_wdata = 32'h0;
    io_din = 32'h0;
    #1;
    chk_a("reset_a", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    chk_l("reset_l", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    repeat (2) next_cyc();
    rstn = 1'b1; req_valid = 1'b0; req_valid_l = 1'b0;
    next_cyc(); #1;
    chk_a("idle_a", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 1: direct read of switches
    next_cyc();
    req_valid = 1'b1; req_we = 1'b0; req_poll = 1'b0; req_addr = 8'h04;
    req_wdata = 32'h0; io_din = 32'h0000_A5A5;
    #1 chk_a("rd_c0", 1, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("rd_c1", 1, 0, 0, 0, 1, 8'h04, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("rd_done", 0, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0000_A5A5);
    req_valid = 1'b0;
    next_cyc(); #1 chk_a("rd_idle", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 2: direct write of LEDs
    next_cyc();
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h00; req_wdata = 32'h1234;
    io_din = 32'hFFFF_FFFF;
    #1 chk_a("wr_c0", 1, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("wr_c1", 1, 0, 0, 1, 0, 8'h00, 32'h1234, 32'h0);
    next_cyc(); #1 chk_a("wr_done", 0, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    req_valid = 1'b0;
    next_cyc(); #1 chk_a("wr_idle", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 3: polled read, IN_VLD low for 5 polls then high
    next_cyc();
    req_valid = 1'b1; req_we = 1'b0; req_poll = 1'b1; req_addr = 8'hFF;
    req_wdata = 32'h0; io_din = 32'h0;
    #1 chk_a("prd_c0", 1, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      next_cyc(); #1 chk_a($sformatf("prd_poll%0d", i), 1, 0, 0, 0, 1, 8'h10, 32'h0, 32'h0);
    end
    next_cyc(); io_din = 32'h1;
    #1 chk_a("prd_poll5", 1, 0, 0, 0, 1, 8'h10, 32'h0, 32'h0);
    next_cyc(); io_din = 32'hDEAD_BEEF;
    #1 chk_a("prd_xfer", 1, 0, 0, 0, 1, 8'h14, 32'h0, 32'h0);
    next_cyc(); io_din = 32'h0;
    #1 chk_a("prd_done", 0, 1, 0, 0, 0, 8'h00, 32'h0, 32'hDEAD_BEEF);
    req_valid = 1'b0;
    next_cyc(); #1 chk_a("prd_idle", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 4: polled write, OUT_VLD high for 3 polls then low
    next_cyc();
    req_valid = 1'b1; req_we = 1'b1; req_poll = 1'b1; req_wdata = 32'h55AA_0F0F;
    io_din = 32'h1;
    #1 chk_a("pwr_c0", 1, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      next_cyc(); #1 chk_a($sformatf("pwr_poll%0d", i), 1, 0, 0, 0, 1, 8'h08, 32'h0, 32'h0);
    end
    next_cyc(); io_din = 32'h0;
    #1 chk_a("pwr_poll3", 1, 0, 0, 0, 1, 8'h08, 32'h0, 32'h0);
    next_cyc(); io_din = 32'hFFFF_FFFF;
    #1 chk_a("pwr_xfer", 1, 0, 0, 1, 0, 8'h0C, 32'h55AA_0F0F, 32'h0);
    next_cyc(); #1 chk_a("pwr_done", 0, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    req_valid = 1'b0;
    next_cyc(); #1 chk_a("pwr_idle", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 5: timeout on the POLL_LIMIT=4 instance
    next_cyc();
    req_valid_l = 1'b1; req_we = 1'b0; req_poll = 1'b1; req_wdata = 32'h0;
    io_din = 32'h0;
    #1 chk_l("to_c0", 1, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cyc(); #1 chk_l($sformatf("to_poll%0d", i), 1, 0, 0, 0, 1, 8'h10, 32'h0, 32'h0);
    end
    next_cyc(); #1 chk_l("to_done", 0, 1, 1, 0, 0, 8'h00, 32'h0, 32'h0);
    req_valid_l = 1'b0;
    next_cyc(); #1 chk_l("to_idle", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    chk_a("to_a_quiet", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // 6: reset during POLL
    next_cyc();
    req_valid = 1'b1; req_we = 1'b0; req_poll = 1'b1; io_din = 32'h0;
    next_cyc(); #1 chk_a("rst_poll0", 1, 0, 0, 0, 1, 8'h10, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("rst_poll1", 1, 0, 0, 0, 1, 8'h10, 32'h0, 32'h0);
    #1 rstn = 1'b0;
    #1 chk_a("rst_asserted", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    req_valid = 1'b0; io_din = 32'h1;
    next_cyc(); rstn = 1'b1;
    #1 chk_a("rst_rel0", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("rst_rel1", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("rst_rel2", 0, 0, 0, 0, 0, 8'h00, 32'h0, 32'h0);

    // New direct read after the aborted access
    next_cyc();
    req_valid = 1'b1; req_poll = 1'b0; req_addr = 8'h04; io_din = 32'h0000_0007;
    next_cyc(); #1 chk_a("post_rd_c1", 1, 0, 0, 0, 1, 8'h04, 32'h0, 32'h0);
    next_cyc(); #1 chk_a("post_rd_done", 0, 1, 0, 0, 0, 8'h00, 32'h0, 32'h0000_0007);
    req_valid = 1'b0;
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule
